// File: rtl/adder.sv
// Parameterised ripple-carry adder: a generate chain of full_adder cells with a
// combinational sum/carry and a registered copy. Define ADDER_OVF_EN to add ovf_q.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

module adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic [WIDTH-1:0] s_q,
`ifdef ADDER_OVF_EN
    output logic             ovf_q,
`endif
    output logic             c_out_q
);

    // w_carry[i] is the carry into cell i; w_carry[WIDTH] leaves the top cell
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;

    assign w_carry[0] = c_in;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : myadder
            full_adder fa (
                .a     (a[i]),
                .b     (b[i]),
                .c_in  (w_carry[i]),
                .s     (w_sum[i]),
                .c_out (w_carry[i+1])
            );
        end
    endgenerate

    assign s     = w_sum;
    assign c_out = w_carry[WIDTH];

    // Registered copy of the sum and carry, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= {WIDTH{1'b0}};
            r_c_out <= 1'b0;
        end else begin
            r_s     <= w_sum;
            r_c_out <= w_carry[WIDTH];
        end
    end

    assign s_q     = r_s;
    assign c_out_q = r_c_out;

`ifdef ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: carry into the sign bit disagrees with carry out of it
    assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    // Overflow flag registered alongside s_q
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf_q = r_ovf;
`endif

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for adder (WIDTH=4): exhaustive sweep, probes,
// boundaries, reset and latency; overflow checks when ADDER_OVF_EN is defined.

module tb_adder;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
`ifdef ADDER_OVF_EN
    logic             ovf_q;
`endif

    int n_checks;
    int n_fail;

    adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .s       (s),
        .c_out   (c_out),
        .s_q     (s_q),
`ifdef ADDER_OVF_EN
        .ovf_q   (ovf_q),
`endif
        .c_out_q (c_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        @(negedge clk);
        a    = va;
        b    = vb;
        c_in = vc;
        #1;
    endtask

    task automatic edge_wait;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_v;
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        a    = 4'd0;
        b    = 4'd0;
        c_in = 1'b0;

        // Reset: combinational sum unaffected, registers cleared
        drive(4'd7, 4'd6, 1'b0);
        check("rst_s_comb", 32'(s), 32'd13);
        edge_wait();
        check("rst_s_q", 32'(s_q), 32'd0);
        check("rst_c_out_q", 32'(c_out_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        edge_wait();
        check("post_rst_s_q", 32'(s_q), 32'd13);
        check("post_rst_c_out_q", 32'(c_out_q), 32'd0);

        // Exhaustive sweep of {a,b,c_in}
        for (int i = 0; i < 512; i++) begin
            exp_v = 5'(i >> 5) + 5'((i >> 1) & 15) + 5'(i & 1);
            drive(4'(i >> 5), 4'((i >> 1) & 15), 1'(i & 1));
            check("sweep_comb", {27'd0, c_out, s}, {27'd0, exp_v});
            edge_wait();
            check("sweep_reg", {27'd0, c_out_q, s_q}, {27'd0, exp_v});
        end

        drive(4'd9, 4'd8, 1'b1);
        check("ex_9_8_1_s", 32'(s), 32'd2);
        check("ex_9_8_1_c", 32'(c_out), 32'd1);

        // Hierarchical probe of cell 0
        drive(4'd1, 4'd1, 1'b0);
        check("probe_a", 32'(dut.myadder[0].fa.a), 32'd1);
        check("probe_b", 32'(dut.myadder[0].fa.b), 32'd1);
        check("probe_cin", 32'(dut.myadder[0].fa.c_in), 32'd0);
        check("probe_s", 32'(dut.myadder[0].fa.s), 32'd0);
        check("probe_cout", 32'(dut.myadder[0].fa.c_out), 32'd1);
        check("probe_port_s", 32'(s), 32'd2);
        check("probe_port_c", 32'(c_out), 32'd0);

        // Boundaries
        drive(4'd15, 4'd15, 1'b1);
        check("wrap_s", 32'(s), 32'd15);
        check("wrap_c", 32'(c_out), 32'd1);
        edge_wait();
        check("wrap_s_q", 32'(s_q), 32'd15);
        check("wrap_c_out_q", 32'(c_out_q), 32'd1);
        drive(4'd0, 4'd0, 1'b0);
        check("zero_s", 32'(s), 32'd0);
        check("zero_c", 32'(c_out), 32'd0);
        drive(4'd15, 4'd0, 1'b1);
        check("max1_s", 32'(s), 32'd0);
        check("max1_c", 32'(c_out), 32'd1);

        // Latency: s moves immediately, s_q one edge later
        drive(4'd3, 4'd4, 1'b0);
        check("lat_s_7", 32'(s), 32'd7);
        edge_wait();
        check("lat_s_q_7", 32'(s_q), 32'd7);
        drive(4'd10, 4'd10, 1'b0);
        check("lat_s_4", 32'(s), 32'd4);
        check("lat_c_1", 32'(c_out), 32'd1);
        check("lat_s_q_hold", 32'(s_q), 32'd7);
        check("lat_c_out_q_hold", 32'(c_out_q), 32'd0);
        edge_wait();
        check("lat_s_q_4", 32'(s_q), 32'd4);
        check("lat_c_out_q_1", 32'(c_out_q), 32'd1);

        // Mid-stream reset
        drive(4'd15, 4'd15, 1'b0);
        rst = 1'b1;
        edge_wait();
        check("mid_rst_s_q", 32'(s_q), 32'd0);
        check("mid_rst_c_out_q", 32'(c_out_q), 32'd0);
        check("mid_rst_s", 32'(s), 32'd14);
        check("mid_rst_c", 32'(c_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        edge_wait();
        check("mid_rel_s_q", 32'(s_q), 32'd14);
        check("mid_rel_c_out_q", 32'(c_out_q), 32'd1);

`ifdef ADDER_OVF_EN
        drive(4'd7, 4'd1, 1'b0);
        check("ovf_7_1_s", 32'(s), 32'd8);
        edge_wait();
        check("ovf_7_1", 32'(ovf_q), 32'd1);
        drive(4'd8, 4'd8, 1'b0);
        check("ovf_8_8_s", 32'(s), 32'd0);
        check("ovf_8_8_c", 32'(c_out), 32'd1);
        edge_wait();
        check("ovf_8_8", 32'(ovf_q), 32'd1);
        drive(4'd3, 4'd2, 1'b0);
        edge_wait();
        check("ovf_3_2", 32'(ovf_q), 32'd0);
        drive(4'd7, 4'd1, 1'b0);
        rst = 1'b1;
        edge_wait();
        check("ovf_rst", 32'(ovf_q), 32'd0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- Parameterised ripple-carry adder built from a generate chain of 1-bit full-adder cells.
- Provides a combinational sum/carry path and a registered copy of the same result.
- Used as a datapath arithmetic primitive.
- Clocked portion uses the common system clock and synchronous reset.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- s  output  WIDTH  combinational sum, equal to (a+b+c_in) mod 2^WIDTH.
- c_out  output  1  combinational carry out of bit WIDTH-1.
- s_q  output  WIDTH  registered s.
- c_out_q  output  1  registered c_out.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Structure: generate loop labelled myadder, index i from 0 to WIDTH-1.
  - Each iteration instantiates a cell named fa of module full_adder.
  - full_adder ports are exactly a, b, c_in, s, c_out; all are 1 bit.
  - Hierarchical probes such as myadder[0].fa.a must resolve.
- full_adder function: s = a^b^c_in; c_out = (a&b)|(a&c_in)|(b&c_in).
- Chaining rules:
  - Cell 0 c_in = port c_in.
  - Cell i c_in = cell i-1 c_out.
  - Cell i s drives s[i].
  - Port c_out = cell WIDTH-1 c_out.
- Combinational path:
  - s and c_out have zero latency and no dependence on clk or rst.
  - {c_out,s} equals a+b+c_in computed at WIDTH+1 bits.
- Registered path:
  - On each rising clk with rst=0: s_q <= s and c_out_q <= c_out.
  - Latency is 1 cycle, with no enable.
- Reset:
  - rst=1 at a rising edge forces s_q=0 and c_out_q=0.
  - Reset does not affect s or c_out.
  - Reset asserted mid-stream clears the registers on that edge.
  - The first edge after rst deasserts captures the then-current sum.
- Boundary conditions:
  - Wrap-around: a=b=2^WIDTH-1 with c_in=1 gives s=2^WIDTH-1 and c_out=1.
  - All-zero inputs give s=0, c_out=0.
  - Maximum single-operand input plus c_in=1 gives s=0, c_out=1.
- Power-up: register values before the first reset are don't-care.
- Synthesis: no latches; no X is produced on any output when inputs are known.

Optional Feature:
- Macro: ADDER_OVF_EN.
- When defined:
  - Adds output ovf_q (1 bit, registered).
  - ovf_q holds the two's-complement overflow of the sum: carry into bit WIDTH-1 XOR c_out.
  - ovf_q is captured with the same timing as s_q.
  - ovf_q resets to 0 on rst.
- When undefined:
  - Port ovf_q does not exist.
  - No overflow logic is built.
  - All other behaviour is identical.

Test Plan:
- Exhaustive WIDTH=4: drive {a,b,c_in} = counter 0..511, one value per cycle.
  - Every cycle {c_out,s} must equal a+b+c_in.
  - Example: a=9, b=8, c_in=1 -> s=2, c_out=1.
- Probe check: a=1, b=1, c_in=0.
  - myadder[0].fa shows a=1, b=1, c_in=0, s=0, c_out=1.
  - Port s=2, c_out=0.
- Wrap-around: a=15, b=15, c_in=1 -> s=15, c_out=1.
  - Next edge: s_q=15, c_out_q=1.
- Reset: hold rst=1 with a=7, b=6, c_in=0.
  - s=13 combinationally; s_q=0 and c_out_q=0 after the edge.
  - Deassert rst: s_q=13 one edge later.
- Latency: change inputs from 3+4 to 10+10 between edges.
  - s updates immediately (7 then 4 with c_out=1).
  - s_q lags by exactly one edge (7 then 4, c_out_q=1).
- ADDER_OVF_EN, WIDTH=4:
  - a=7, b=1, c_in=0 -> s=8, ovf_q=1 next edge.
  - a=8, b=8 -> s=0, c_out=1, ovf_q=1.
  - a=3, b=2 -> ovf_q=0.
